// File: rtl/monte_carlo_scheduler.sv
// Monte Carlo move chooser: drives one logic2048 engine through TRIALS random
// playouts per first-move direction and reports the direction that survives longest.
module monte_carlo_scheduler #(
  parameter int          TRIALS    = 16,
  parameter int          MAX_STEPS = 1023,
  parameter int          SCORE_W   = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [79:0]        initial_board,
  input  logic [1:0]         restrected,
  input  logic [2:0]         restrect_prob,
  output logic               busy,
  output logic               result_valid,
  output logic [1:0]         best_dir,
  output logic [SCORE_W-1:0] best_score,
  output logic               eng_load,
  output logic [79:0]        eng_board,
  output logic               eng_req,
  output logic [1:0]         eng_dir,
  input  logic               eng_ack,
  input  logic               eng_moved,
  input  logic               eng_stuck
);

  localparam int TRIAL_W = (TRIALS > 1) ? $clog2(TRIALS) : 1;
  localparam int STEP_W  = $clog2(MAX_STEPS + 1);
  localparam int SUM_W   = ((SCORE_W > STEP_W) ? SCORE_W : STEP_W) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FIRST,
    S_DRAW,
    S_RAND,
    S_END_PLAY,
    S_NEXT_DIR,
    S_COMPARE
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [15:0]          r_lfsr;
  logic [79:0]          r_board;
  logic [1:0]           r_restr;
  logic [2:0]           r_prob;
  logic [1:0]           r_dir_idx;
  logic [1:0]           r_rand_dir;
  logic [TRIAL_W-1:0]   r_trial;
  logic [STEP_W-1:0]    r_steps;
  logic [SCORE_W-1:0]   r_score [4];
  logic                 r_result_valid;
  logic [1:0]           r_best_dir;
  logic [SCORE_W-1:0]   r_best_score;

  logic                 w_lfsr_fb;
  logic                 w_draw_reject;
  logic                 w_last_trial;
  logic [STEP_W-1:0]    w_steps_inc;
  logic [SUM_W-1:0]     w_sum;
  logic [SCORE_W-1:0]   w_score_sat;
  logic [1:0]           w_win_dir;
  logic [SCORE_W-1:0]   w_win_score;

  assign w_lfsr_fb     = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  // The restricted direction is only accepted when the 3-bit draw is below the threshold.
  assign w_draw_reject = (r_lfsr[1:0] == r_restr) && (r_lfsr[4:2] >= r_prob);
  assign w_last_trial  = (r_trial == TRIAL_W'(TRIALS - 1));
  assign w_steps_inc   = r_steps + STEP_W'(eng_moved);
  assign w_sum         = SUM_W'(r_score[r_dir_idx]) + SUM_W'(r_steps);
  assign w_score_sat   = (|w_sum[SUM_W-1:SCORE_W]) ? {SCORE_W{1'b1}} : w_sum[SCORE_W-1:0];

  // Strict '>' keeps the lower direction index on ties.
  always_comb begin
    w_win_dir   = 2'd0;
    w_win_score = r_score[0];
    for (int d = 1; d < 4; d++) begin
      if (r_score[d] > w_win_score) begin
        w_win_dir   = 2'(d);
        w_win_score = r_score[d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    busy        = (r_state != S_IDLE);
    eng_load    = 1'b0;
    eng_req     = 1'b0;
    eng_dir     = r_dir_idx;
    case (r_state)
      S_IDLE:     if (start) w_state_nxt = S_LOAD;
      S_LOAD: begin
        eng_load    = 1'b1;
        w_state_nxt = S_FIRST;
      end
      S_FIRST: begin
        eng_req = 1'b1;
        if (eng_ack) begin
          if (!eng_moved)     w_state_nxt = S_NEXT_DIR;
          else if (eng_stuck) w_state_nxt = S_END_PLAY;
          else                w_state_nxt = S_DRAW;
        end
      end
      S_DRAW:     if (!w_draw_reject) w_state_nxt = S_RAND;
      S_RAND: begin
        eng_req = 1'b1;
        eng_dir = r_rand_dir;
        if (eng_ack) begin
          if (eng_stuck || (w_steps_inc == STEP_W'(MAX_STEPS))) w_state_nxt = S_END_PLAY;
          else                                                  w_state_nxt = S_DRAW;
        end
      end
      S_END_PLAY: w_state_nxt = w_last_trial ? S_NEXT_DIR : S_LOAD;
      S_NEXT_DIR: w_state_nxt = (r_dir_idx == 2'd3) ? S_COMPARE : S_LOAD;
      S_COMPARE:  w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr         <= LFSR_SEED;
      r_board        <= '0;
      r_restr        <= '0;
      r_prob         <= '0;
      r_dir_idx      <= '0;
      r_rand_dir     <= '0;
      r_trial        <= '0;
      r_steps        <= '0;
      r_result_valid <= 1'b0;
      r_best_dir     <= '0;
      r_best_score   <= '0;
      // NOTE: the four accumulators are plain registers, not a RAM, so resetting them is cheap.
      for (int d = 0; d < 4; d++) r_score[d] <= '0;
    end else begin
      r_lfsr         <= {r_lfsr[14:0], w_lfsr_fb};
      r_result_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_board   <= initial_board;
            r_restr   <= restrected;
            r_prob    <= restrect_prob;
            r_dir_idx <= '0;
            r_trial   <= '0;
            for (int d = 0; d < 4; d++) r_score[d] <= '0;
          end
        end
        S_LOAD:  r_steps <= '0;
        S_FIRST: if (eng_ack && !eng_moved) r_score[r_dir_idx] <= '0;
        S_DRAW:  if (!w_draw_reject) r_rand_dir <= r_lfsr[1:0];
        S_RAND:  if (eng_ack) r_steps <= w_steps_inc;
        S_END_PLAY: begin
          r_score[r_dir_idx] <= w_score_sat;
          r_trial            <= r_trial + TRIAL_W'(1);
        end
        S_NEXT_DIR: begin
          r_trial   <= '0;
          r_dir_idx <= r_dir_idx + 2'd1;
        end
        S_COMPARE: begin
          r_best_dir     <= w_win_dir;
          r_best_score   <= w_win_score;
          r_result_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign result_valid = r_result_valid;
  assign best_dir     = r_best_dir;
  assign best_score   = r_best_score;
  assign eng_board    = r_board;

endmodule

// File: tb/tb_monte_carlo_scheduler.sv
// Bench for monte_carlo_scheduler: a behavioural engine stub doubles as a playout-level
// scoreboard; directed table rows, randomized rows and hand-written reset/start corner cases.
module tb_monte_carlo_scheduler;

  localparam int TRIALS    = 4;
  localparam int MAX_STEPS = 40;
  localparam int SCORE_W   = 7;
  localparam int SAT       = (1 << SCORE_W) - 1;

  typedef struct {
    bit              rnd;
    logic [1:0]      restr;
    logic [2:0]      prob;
    logic [3:0]      first_ok;
    logic [3:0][7:0] stuck;
    bit              chk_exp;
    logic [1:0]      exp_dir;
    int              exp_score;
    bit              want_restr;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [79:0]        initial_board = '0;
  logic [1:0]         restrected = '0;
  logic [2:0]         restrect_prob = '0;
  logic               busy, result_valid, eng_load, eng_req;
  logic [1:0]         best_dir, eng_dir;
  logic [SCORE_W-1:0] best_score;
  logic [79:0]        eng_board;
  logic               stub_ack = 1'b0, tb_ack = 1'b0;
  logic               eng_moved = 1'b0, eng_stuck = 1'b0;

  monte_carlo_scheduler #(.TRIALS(TRIALS), .MAX_STEPS(MAX_STEPS), .SCORE_W(SCORE_W)) dut (
    .clk(clk), .rst(rst), .start(start), .initial_board(initial_board),
    .restrected(restrected), .restrect_prob(restrect_prob), .busy(busy),
    .result_valid(result_valid), .best_dir(best_dir), .best_score(best_score),
    .eng_load(eng_load), .eng_board(eng_board), .eng_req(eng_req), .eng_dir(eng_dir),
    .eng_ack(stub_ack | tb_ack), .eng_moved(eng_moved), .eng_stuck(eng_stuck)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Stub configuration and playout-level model state
  bit              cfg_rnd = 1'b0;
  bit              stub_hold = 1'b0;
  logic [3:0]      cfg_first_ok = 4'hF;
  logic [3:0][7:0] cfg_stuck = '0;
  logic [1:0]      cfg_restr = '0;
  logic [79:0]     m_board = '0;
  int              m_dir = 0, m_trial = 0, m_steps = 0;
  bit              m_in_play = 1'b0, m_first = 1'b0;
  int              m_score [4];
  int              rv_count = 0, restr_hits = 0;
  bit              pending = 1'b0;
  int              wait_left = 0;

  function automatic logic [3:0][7:0] mk_stuck(input int s0, input int s1, input int s2, input int s3);
    return {8'(s3), 8'(s2), 8'(s1), 8'(s0)};
  endfunction

  task automatic model_reset(input logic [79:0] board);
    m_board   = board;
    m_dir     = 0;
    m_trial   = 0;
    m_steps   = 0;
    m_in_play = 1'b0;
    m_first   = 1'b0;
    for (int i = 0; i < 4; i++) m_score[i] = 0;
  endtask

  function automatic void model_best(output int d, output int s);
    d = 0;
    s = m_score[0];
    for (int i = 1; i < 4; i++) if (m_score[i] > s) begin d = i; s = m_score[i]; end
  endfunction

  task automatic end_playout();
    m_score[m_dir] = (m_score[m_dir] + m_steps > SAT) ? SAT : m_score[m_dir] + m_steps;
    m_in_play = 1'b0;
    m_trial++;
    if (m_trial == TRIALS) begin m_dir++; m_trial = 0; end
  endtask

  task automatic respond();
    logic mv, st;
    mv = 1'b0;
    st = 1'b1;
    check("req_in_playout", m_in_play, 1);
    if (m_in_play && m_first) begin
      check("first_dir", eng_dir, m_dir);
      if (cfg_rnd) begin mv = ($urandom_range(0, 7) != 0); st = ($urandom_range(0, 7) == 0); end
      else begin mv = cfg_first_ok[m_dir]; st = (cfg_stuck[m_dir] == 8'd0); end
      if (!mv) begin
        m_score[m_dir] = 0;
        m_dir++;
        m_trial   = 0;
        m_in_play = 1'b0;
      end else if (st) end_playout();
      else m_first = 1'b0;
    end else if (m_in_play) begin
      if (eng_dir == cfg_restr) restr_hits++;
      if (cfg_rnd) begin mv = ($urandom_range(0, 3) != 0); st = ($urandom_range(0, 15) == 0); end
      else begin mv = 1'b1; st = (m_steps + 1 == int'(cfg_stuck[m_dir])); end
      if (mv) m_steps++;
      if (st || m_steps == MAX_STEPS) end_playout();
    end
    stub_ack  = 1'b1;
    eng_moved = mv;
    eng_stuck = st;
  endtask

  // Engine stub: acts 1 time unit after each rising edge, random 0..2 cycle ack latency.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      stub_ack  = 1'b0;
      eng_moved = 1'b0;
      eng_stuck = 1'b0;
      if (result_valid) rv_count++;
      if (rst) pending = 1'b0;
      else if (eng_load) begin
        check("load_expected", (m_dir < 4) && !m_in_play, 1);
        check("eng_board", eng_board, m_board);
        m_in_play = 1'b1;
        m_first   = 1'b1;
        m_steps   = 0;
      end else if (eng_req && !(stub_hold && m_in_play && !m_first)) begin
        if (!pending) begin pending = 1'b1; wait_left = $urandom_range(0, 2); end
        if (wait_left == 0) begin pending = 1'b0; respond(); end
        else wait_left--;
      end
    end
  end

  task automatic run_vec(input vec_t v, input int spur_at);
    logic [79:0] board;
    bit got;
    int ed, es;
    board = {16'($urandom), $urandom, $urandom};
    if (v.rnd) begin v.restr = 2'($urandom); v.prob = 3'($urandom); end
    cfg_rnd      = v.rnd;
    cfg_first_ok = v.first_ok;
    cfg_stuck    = v.stuck;
    cfg_restr    = v.restr;
    model_reset(board);
    rv_count      = 0;
    restr_hits    = 0;
    initial_board = board;
    restrected    = v.restr;
    restrect_prob = v.prob;
    start         = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("load_after_start", eng_load, 1);
    got = 1'b0;
    for (int cyc = 0; cyc < 6000 && !got; cyc++) begin
      if (cyc == spur_at) begin
        initial_board = ~board;
        restrected    = v.restr + 2'd1;
        restrect_prob = 3'd7;
        start         = 1'b1;
      end else start = 1'b0;
      @(negedge clk);
      if (result_valid) got = 1'b1;
    end
    start = 1'b0;
    check("result_in_budget", got, 1);
    if (got) begin
      model_best(ed, es);
      check("busy_low_with_result", busy, 0);
      check("all_dirs_played", m_dir, 4);
      check("best_dir_model", best_dir, ed);
      check("best_score_model", best_score, es);
      if (v.chk_exp) begin
        check("best_dir_table", best_dir, v.exp_dir);
        check("best_score_table", best_score, v.exp_score);
      end
      if (v.prob == 3'd0) check("restricted_never_drawn", restr_hits, 0);
      if (v.want_restr)   check("restricted_drawn", restr_hits > 0, 1);
      repeat (3) @(negedge clk);
      check("result_valid_once", rv_count, 1);
      check("idle_after_result", busy, 0);
    end
  endtask

  vec_t vecs[$];

  initial begin
    bit got;
    // rnd, restr, prob, first_ok, stuck-after per dir, chk_exp, exp_dir, exp_score, want_restr
    vecs.push_back('{1'b0, 2'd0, 3'd7, 4'hF, mk_stuck(2, 2, 5, 2),         1'b1, 2'd2, 20,  1'b0});
    vecs.push_back('{1'b0, 2'd0, 3'd7, 4'hC, mk_stuck(2, 2, 3, 4),         1'b1, 2'd3, 16,  1'b0});
    vecs.push_back('{1'b0, 2'd3, 3'd0, 4'hF, mk_stuck(255, 255, 255, 255), 1'b1, 2'd0, SAT, 1'b0});
    vecs.push_back('{1'b0, 2'd3, 3'd7, 4'hF, mk_stuck(255, 255, 255, 255), 1'b1, 2'd0, SAT, 1'b1});
    vecs.push_back('{1'b0, 2'd1, 3'd4, 4'h0, mk_stuck(2, 2, 2, 2),         1'b1, 2'd0, 0,   1'b0});
    vecs.push_back('{1'b0, 2'd2, 3'd3, 4'hF, mk_stuck(0, 3, 0, 1),         1'b1, 2'd1, 12,  1'b0});
    vecs.push_back('{1'b0, 2'd0, 3'd5, 4'hF, mk_stuck(2, 45, 3, 1),        1'b1, 2'd1, SAT, 1'b0});
    vecs.push_back('{1'b0, 2'd1, 3'd6, 4'hF, mk_stuck(10, 40, 41, 12),     1'b1, 2'd1, SAT, 1'b0});
    vecs.push_back('{1'b0, 2'd2, 3'd2, 4'hB, mk_stuck(1, 2, 30, 3),        1'b1, 2'd3, 12,  1'b0});
    for (int i = 0; i < 3; i++)
      vecs.push_back('{1'b1, 2'd0, 3'd0, 4'hF, mk_stuck(0, 0, 0, 0),       1'b0, 2'd0, 0,   1'b0});

    for (int i = 0; i < 4; i++) m_score[i] = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_best_dir", best_dir, 0);
    check("rst_best_score", best_score, 0);
    check("rst_eng_load", eng_load, 0);
    check("rst_eng_req", eng_req, 0);
    check("rst_eng_dir", eng_dir, 0);

    // Stray ack while idle must not wake the scheduler.
    tb_ack = 1'b1;
    @(negedge clk);
    tb_ack = 1'b0;
    check("stray_ack_busy", busy, 0);
    check("stray_ack_req", eng_req, 0);
    check("stray_ack_load", eng_load, 0);
    @(negedge clk);
    check("stray_ack_busy_later", busy, 0);

    foreach (vecs[i]) run_vec(vecs[i], -1);

    // Start pulsed mid-run with different inputs: must be ignored.
    vecs[0].restr = 2'd3;
    vecs[0].prob  = 3'd0;
    run_vec(vecs[0], 20);

    // Synchronous reset while a random move is outstanding.
    cfg_rnd      = 1'b0;
    cfg_first_ok = 4'hF;
    cfg_stuck    = mk_stuck(255, 255, 255, 255);
    stub_hold    = 1'b1;
    model_reset({16'($urandom), $urandom, $urandom});
    initial_board = m_board;
    restrected    = 2'd0;
    restrect_prob = 3'd7;
    start         = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got   = 1'b0;
    for (int cyc = 0; cyc < 200 && !got; cyc++) begin
      @(negedge clk);
      if (eng_req && m_in_play && !m_first) got = 1'b1;
    end
    check("reached_random_move", got, 1);
    check("req_high_before_rst", eng_req, 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_eng_req", eng_req, 0);
    check("abort_busy", busy, 0);
    check("abort_result_valid", result_valid, 0);
    check("abort_best_dir", best_dir, 0);
    check("abort_best_score", best_score, 0);
    check("abort_eng_load", eng_load, 0);
    check("abort_eng_dir", eng_dir, 0);
    rst       = 1'b0;
    stub_hold = 1'b0;
    @(negedge clk);
    run_vec(vecs[1], -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/monte_carlo_scheduler.md
Name: monte_carlo_scheduler

Overview:
Sequences the 2048 game-logic engine through Monte Carlo playouts to choose the best next move for a given board. For each of the 4 first-move directions it runs TRIALS playouts. Each playout loads the initial board, applies the forced first move, then plays LFSR-random moves until the engine reports stuck or MAX_STEPS is reached. It accumulates survival steps per direction and reports the winning direction and its score. It sits between the top-level move controller and one logic2048 engine instance, and is the engine's only requester.

Parameters:
TRIALS, 16, playouts per first-move direction (1..65535)
MAX_STEPS, 1023, cap on random moves counted per playout
SCORE_W, 16, width of per-direction score accumulators (saturating)
LFSR_SEED, 16'hACE1, nonzero reset value of internal 16-bit Fibonacci LFSR (taps 16,14,13,11)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  one-cycle pulse; latches initial_board, restrected, restrect_prob; ignored while busy
initial_board  in  80  16 cells x 5-bit log2 tile values
restrected  in  2  restricted direction (0 up, 1 down, 2 left, 3 right)
restrect_prob  in  3  acceptance threshold for the restricted direction in random moves, 0..7
busy  out  1  high from the cycle after accepted start until result_valid
result_valid  out  1  one-cycle pulse when best_dir/best_score are updated
best_dir  out  2  winning first-move direction
best_score  out  SCORE_W  winning accumulated step count
eng_load  out  1  one-cycle pulse; engine loads eng_board; engine is ready the next cycle
eng_board  out  80  latched initial board
eng_req  out  1  move request; held high until eng_ack
eng_dir  out  2  move direction; stable while eng_req is high
eng_ack  in  1  one-cycle pulse completing a request
eng_moved  in  1  valid with eng_ack: the move changed the board
eng_stuck  in  1  valid with eng_ack: the resulting board has no legal move

Behaviour:
- Reset values: busy=0, result_valid=0, best_dir=0, best_score=0, eng_load=0, eng_req=0, eng_dir=0, all counters 0, LFSR=LFSR_SEED. A reset mid-operation aborts to IDLE immediately, drives eng_req low, and discards partial results.
- The LFSR advances every cycle. Random-move draws use lfsr[1:0] as the direction and lfsr[4:2] as the probability draw.
- FSM states:
  - IDLE: on start, latch inputs, clear the 4 score accumulators, dir_idx=0, trial=0 -> LOAD.
  - LOAD: assert eng_load for 1 cycle, steps=0 -> FIRST.
  - FIRST: eng_req=1, eng_dir=dir_idx; wait for eng_ack.
    - !eng_moved: score[dir_idx]=0; skip all remaining trials for this direction -> NEXT_DIR.
    - eng_moved && eng_stuck -> END_PLAY (steps=0).
    - else -> DRAW.
  - DRAW: 1 cycle.
    - If lfsr[1:0]==restrected and lfsr[4:2] >= restrect_prob, redraw next cycle (stay in DRAW).
    - Otherwise latch the direction -> RAND.
    - restrect_prob=0 therefore never selects the restricted direction.
  - RAND: eng_req=1 with the latched direction; wait for eng_ack.
    - eng_moved: steps+1.
    - eng_stuck, or steps reaches MAX_STEPS -> END_PLAY.
    - else -> DRAW. An illegal move (!eng_moved && !eng_stuck) costs no step.
  - END_PLAY: score[dir_idx] += steps, saturating at 2^SCORE_W-1; trial+1.
    - trial==TRIALS -> NEXT_DIR.
    - else -> LOAD.
  - NEXT_DIR: trial=0; dir_idx+1.
    - dir_idx was 3 -> COMPARE.
    - else -> LOAD.
  - COMPARE: 1 cycle. Pick the highest score; on a tie the lower direction index wins (strict > replaces). Update best_dir/best_score, pulse result_valid -> IDLE.
- busy drops in the same cycle that result_valid pulses.
- All 4 scores 0: best_dir=0, best_score=0.
- eng_ack is only sampled while eng_req is high; a stray ack in other states is ignored.
- Latency with a zero-wait engine: per playout = 1 (LOAD) + first move + sum over random moves of (DRAW cycles + ack wait) + 1.

Test Plan:
- Stub engine acks after 1 cycle; dir 2 is stuck after 5 legal moves, others after 2; TRIALS=4 -> scores {8,8,20,8}; best_dir=2, best_score=20; result_valid pulses exactly once.
- Stub returns eng_moved=0 on the first move for dirs 0 and 1 -> no further LOAD/req for those dirs; score 0; best chosen from dirs 2/3.
- Engine never stuck, always moves; MAX_STEPS=1023, TRIALS=1 -> each score 1023; tie resolves to best_dir=0.
- restrected=3, restrect_prob=0, 10k random requests -> eng_dir never 3 in RAND; restrect_prob=7 -> dir 3 appears at a nonzero rate.
- Assert rst mid-RAND with eng_req high -> the next cycle shows eng_req=0, busy=0, and outputs at reset values; a new start then completes normally.
- start pulsed while busy -> ignored, inputs not re-latched; eng_ack pulsed in IDLE -> no state change.
